// File: rtl/register_file_mp_if.sv
// Decode-stage register file bus: write, reserve, clear-sweep control and
// the packed multi-port read path.
interface register_file_mp_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int NUM_RD = 2
);
    logic                       wen;
    logic [ADDR_W-1:0]          waddr;
    logic [DATA_W-1:0]          wdata;
    logic [NUM_RD*ADDR_W-1:0]   raddr;
    logic [NUM_RD*DATA_W-1:0]   rdata;
    logic [NUM_RD-1:0]          busy;
    logic                       rsv_en;
    logic [ADDR_W-1:0]          rsv_addr;
    logic                       clr_req;
    logic                       clr_busy;

    modport master (
        output wen, waddr, wdata, raddr, rsv_en, rsv_addr, clr_req,
        input  rdata, busy, clr_busy
    );

    modport slave (
        input  wen, waddr, wdata, raddr, rsv_en, rsv_addr, clr_req,
        output rdata, busy, clr_busy
    );
endinterface

// File: rtl/register_file_mp.sv
// Parametrised multi-read-port register file with pending scoreboard and a
// sequenced clear sweep. Optional write-through forwarding: RF_BYPASS_EN.
module register_file_mp_rd_port #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int DEPTH  = 32
) (
    input  logic [DEPTH-1:0][DATA_W-1:0] regs,
    input  logic [DEPTH-1:0]             pend,
    input  logic [ADDR_W-1:0]            raddr,
    input  logic                         fwd_hit,
    input  logic [DATA_W-1:0]            fwd_data,
    input  logic                         fwd_busy,
    output logic [DATA_W-1:0]            rdata,
    output logic                         busy
);
    assign rdata = fwd_hit ? fwd_data : regs[raddr];
    assign busy  = fwd_hit ? fwd_busy : pend[raddr];
endmodule

module register_file_mp #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int NUM_RD   = 2,
    parameter int ZERO_REG = 1
) (
    input  logic               clk,
    input  logic               nRST,
    register_file_mp_if.slave  bus
);
    localparam int DEPTH = 1 << ADDR_W;
    localparam logic [0:0] IDLE  = 1'b0;
    localparam logic [0:0] SWEEP = 1'b1;

    logic [DEPTH-1:0][DATA_W-1:0] regs;
    logic [DEPTH-1:0]             pend;
    logic [0:0]                   state;
    logic [ADDR_W-1:0]            cnt;

    logic idle, wr_ok, rsv_ok;

    // Index 0 is neither writable nor reservable when hardwired to zero,
    // which keeps regs[0] and pend[0] at their reset value of 0.
    assign idle   = (state == IDLE);
    assign wr_ok  = bus.wen && idle && !((ZERO_REG != 0) && (bus.waddr == '0));
    assign rsv_ok = bus.rsv_en && idle && !((ZERO_REG != 0) && (bus.rsv_addr == '0));
    assign bus.clr_busy = (state == SWEEP);

    always_ff @(posedge clk) begin
        if (!nRST) begin
            regs  <= '0;
            pend  <= '0;
            state <= IDLE;
            cnt   <= '0;
        end else if (state == SWEEP) begin
            regs[cnt] <= '0;
            pend[cnt] <= 1'b0;
            cnt       <= cnt + 1'b1;
            if (cnt == ADDR_W'(DEPTH - 1))
                state <= IDLE;
        end else begin
            if (wr_ok) begin
                regs[bus.waddr] <= bus.wdata;
                pend[bus.waddr] <= 1'b0;
            end
            // Later assignment: a same-index reserve overrides the write's clear.
            if (rsv_ok)
                pend[bus.rsv_addr] <= 1'b1;
            if (bus.clr_req) begin
                state <= SWEEP;
                cnt   <= '0;
            end
        end
    end

    for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
        logic [ADDR_W-1:0] ra;
        logic [DATA_W-1:0] rd;
        logic              bz;
        logic              hit, hit_busy;

        assign ra = bus.raddr[i*ADDR_W +: ADDR_W];
`ifdef RF_BYPASS_EN
        assign hit      = wr_ok && (bus.waddr == ra);
        assign hit_busy = rsv_ok && (bus.rsv_addr == ra);
`else
        assign hit      = 1'b0;
        assign hit_busy = 1'b0;
`endif
        register_file_mp_rd_port #(
            .DATA_W (DATA_W),
            .ADDR_W (ADDR_W),
            .DEPTH  (DEPTH)
        ) u_rd (
            .regs     (regs),
            .pend     (pend),
            .raddr    (ra),
            .fwd_hit  (hit),
            .fwd_data (bus.wdata),
            .fwd_busy (hit_busy),
            .rdata    (rd),
            .busy     (bz)
        );
        assign bus.rdata[i*DATA_W +: DATA_W] = rd;
        assign bus.busy[i]                   = bz;
    end
endmodule

// File: tb/tb_register_file_mp.sv
// Randomised and directed bench for register_file_mp against an array-based
// reference model of contents, pending flags and the clear sweep.
module tb_register_file_mp;
    localparam int DATA_W = 32;
    localparam int ADDR_W = 5;
    localparam int NUM_RD = 2;
    localparam int DEPTH  = 32;

    logic clk = 1'b0;
    logic nRST = 1'b0;
    always #5 clk = ~clk;

    register_file_mp_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .NUM_RD(NUM_RD)) bus();

    register_file_mp #(
        .DATA_W(DATA_W), .ADDR_W(ADDR_W), .NUM_RD(NUM_RD), .ZERO_REG(1)
    ) dut (
        .clk  (clk),
        .nRST (nRST),
        .bus  (bus)
    );

    logic [DATA_W-1:0] m_reg [DEPTH];
    bit                m_pend [DEPTH];
    bit                m_sweep;
    int                m_idx;
    int                n_chk = 0;
    int                n_fail = 0;
    logic              last_cb;

    task automatic chk(input string tag, input logic [DATA_W-1:0] obs, input logic [DATA_W-1:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic set_rd(input int a0, input int a1);
        bus.raddr = {ADDR_W'(a1), ADDR_W'(a0)};
    endtask

    task automatic idle_in();
        bus.wen = 0; bus.waddr = '0; bus.wdata = '0;
        bus.rsv_en = 0; bus.rsv_addr = '0; bus.clr_req = 0;
    endtask

    // Check outputs mid-cycle against the model, then advance the model at the edge.
    task automatic tick(input bit do_chk);
        @(negedge clk);
        last_cb = bus.clr_busy;
        if (do_chk) begin
            for (int i = 0; i < NUM_RD; i++) begin
                int ra;
                logic [DATA_W-1:0] er;
                bit eb;
                ra = int'(bus.raddr[i*ADDR_W +: ADDR_W]);
                er = m_reg[ra];
                eb = m_pend[ra];
`ifdef RF_BYPASS_EN
                if (bus.wen && !m_sweep && ra != 0 && int'(bus.waddr) == ra) begin
                    er = bus.wdata;
                    eb = bus.rsv_en && int'(bus.rsv_addr) == ra;
                end
`endif
                chk($sformatf("rdata%0d[r%0d]", i, ra), bus.rdata[i*DATA_W +: DATA_W], er);
                chk($sformatf("busy%0d[r%0d]", i, ra), DATA_W'(bus.busy[i]), DATA_W'(eb));
            end
            chk("clr_busy", DATA_W'(bus.clr_busy), DATA_W'(m_sweep));
        end
        @(posedge clk);
        if (!nRST) begin
            for (int k = 0; k < DEPTH; k++) begin m_reg[k] = '0; m_pend[k] = 0; end
            m_sweep = 0;
        end else if (m_sweep) begin
            m_reg[m_idx] = '0;
            m_pend[m_idx] = 0;
            m_idx++;
            if (m_idx == DEPTH) m_sweep = 0;
        end else begin
            if (bus.wen && bus.waddr != 0) begin
                m_reg[bus.waddr] = bus.wdata;
                m_pend[bus.waddr] = 0;
            end
            if (bus.rsv_en && bus.rsv_addr != 0) m_pend[bus.rsv_addr] = 1;
            if (bus.clr_req) begin m_sweep = 1; m_idx = 0; end
        end
        #1;
    endtask

    task automatic wr(input int a, input logic [DATA_W-1:0] d);
        idle_in();
        bus.wen = 1; bus.waddr = ADDR_W'(a); bus.wdata = d;
        tick(1);
        idle_in();
    endtask

    task automatic read_all();
        idle_in();
        for (int k = 0; k < DEPTH; k += 2) begin
            set_rd(k, k + 1);
            tick(1);
        end
    endtask

    initial begin
        int hi;
        idle_in();
        set_rd(0, 0);
        m_sweep = 0;
        m_idx = 0;
        nRST = 0;
        tick(0);
        tick(0);
        nRST = 1;
        read_all();

        // basic write and read-back
        set_rd(5, 5);
        wr(5, 32'hDEADBEEF);
        tick(1);
        chk("rd_5_p0", bus.rdata[31:0], 32'hDEADBEEF);
        read_all();

        // zero register and zero data
        set_rd(0, 3);
        wr(0, 32'h1234);
        wr(3, 32'h55);
        wr(3, 32'h0);
        tick(1);
        chk("r0_zero", bus.rdata[31:0], 32'h0);

        // same-cycle write/read of reg 7
        wr(7, 32'h11111111);
        set_rd(7, 7);
        wr(7, 32'hA5A5A5A5);
        tick(1);

        // scoreboard
        set_rd(1, 9);
        bus.rsv_en = 1; bus.rsv_addr = 5'd9;
        tick(1);
        idle_in();
        tick(1);
        chk("busy9_set", DATA_W'(bus.busy[1]), 32'd1);
        wr(9, 32'h99);
        tick(1);
        chk("busy9_clr", DATA_W'(bus.busy[1]), 32'd0);
        bus.wen = 1; bus.waddr = 5'd9; bus.wdata = 32'h77;
        bus.rsv_en = 1; bus.rsv_addr = 5'd9;
        tick(1);
        idle_in();
        tick(1);
        chk("busy9_rsv_wins", DATA_W'(bus.busy[1]), 32'd1);
        bus.rsv_en = 1; bus.rsv_addr = 5'd0;
        set_rd(0, 0);
        tick(1);
        idle_in();
        tick(1);

        // full sweep
        for (int k = 1; k < DEPTH; k++) wr(k, 32'h01010101 * k + 32'h1);
        bus.rsv_en = 1; bus.rsv_addr = 5'd20;
        tick(1);
        idle_in();
        bus.clr_req = 1;
        tick(1);
        idle_in();
        hi = 0;
        for (int c = 0; c < 40; c++) begin
            set_rd($urandom_range(DEPTH - 1), $urandom_range(DEPTH - 1));
            if (c == 5) begin bus.wen = 1; bus.waddr = 5'd4; bus.wdata = 32'hBAD0BAD0; end
            if (c == 7) begin bus.rsv_en = 1; bus.rsv_addr = 5'd30; bus.clr_req = 1; end
            tick(1);
            idle_in();
            if (last_cb) hi++;
        end
        chk("sweep_len", DATA_W'(hi), 32'd32);
        read_all();

        // reset mid-sweep
        for (int k = 1; k < 8; k++) wr(k, 32'hC0DE0000 + k);
        bus.clr_req = 1;
        tick(1);
        idle_in();
        for (int c = 0; c < 10; c++) tick(1);
        nRST = 0;
        tick(1);
        nRST = 1;
        chk("clr_busy_after_rst", DATA_W'(bus.clr_busy), 32'd0);
        read_all();
        set_rd(12, 12);
        wr(12, 32'h600D600D);
        tick(1);
        chk("post_rst_wr", bus.rdata[63:32], 32'h600D600D);

        // random traffic
        for (int c = 0; c < 600; c++) begin
            idle_in();
            set_rd($urandom_range(DEPTH - 1), $urandom_range(DEPTH - 1));
            bus.wen      = ($urandom_range(99) < 50);
            bus.waddr    = ADDR_W'($urandom_range(DEPTH - 1));
            bus.wdata    = ($urandom_range(9) == 0) ? '0 : $urandom;
            bus.rsv_en   = ($urandom_range(99) < 30);
            bus.rsv_addr = ($urandom_range(3) == 0) ? bus.waddr : ADDR_W'($urandom_range(DEPTH - 1));
            bus.clr_req  = ($urandom_range(99) == 0);
            nRST         = ($urandom_range(299) != 0);
            tick(1);
        end
        nRST = 1;
        idle_in();
        for (int c = 0; c < DEPTH + 2; c++) tick(1);
        read_all();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
